// File: rtl/lib_cpu.sv
// Shared CPU definitions: ALU control codes used by the ALU control decoder
// and by the serial ALU that executes them.
// Optional feature macro: ALU_SERIAL_MULT_EN (makes ALU_MULT a legal code).
package lib_cpu;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_MULT = 3'b011,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } ALU_CTRL;

    // Codes that run the adder with B inverted and carry-in set.
    function automatic logic uses_sub(input logic [2:0] code);
        return (code == ALU_SUB) || (code == ALU_SLT);
    endfunction

    // Codes the serial ALU actually implements.
    function automatic logic is_legal(input logic [2:0] code);
        logic ok;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: ok = 1'b1;
`ifdef ALU_SERIAL_MULT_EN
            ALU_MULT: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU slice.
// Ports: a, b     slice operands
//        code     ALU control code
//        cin      carry into the slice LSB
//        y        slice result (0 for unsupported codes)
//        cout     carry out of the slice MSB
//        c_msb    carry into the slice MSB (for signed overflow)
module alu_slice
    import lib_cpu::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [2:0]         code,
    input  logic               cin,
    output logic [SLICE_W-1:0] y,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] bx;
    logic [SLICE_W-1:0] sum;

    always_comb begin
        bx = uses_sub(code) ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, bx} + (SLICE_W + 1)'(cin);
        // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
        c_msb = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ bx[SLICE_W-1];
        case (code)
            ALU_AND:                   y = a & b;
            ALU_OR:                    y = a | b;
            ALU_ADD, ALU_SUB, ALU_SLT: y = sum;
            default:                   y = '0;
        endcase
    end

endmodule

// File: rtl/alu_serial_exec.sv
// Multi-cycle ALU: accepts one operation on in_valid/in_ready, processes
// SLICE_W bits per cycle LSB first, returns result/zero/illegal on
// out_valid/out_ready.
// Optional feature macro: ALU_SERIAL_MULT_EN (shift-and-add multiply, WIDTH cycles).
// Ports: clk, reset (sync, active-high)
//        in_valid/in_ready, alu_ctrl_sig, src_a, src_b   request side
//        out_valid/out_ready, result, zero, illegal      response side
module alu_serial_exec
    import lib_cpu::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SLICE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl_sig,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] SMASK = {WIDTH{1'b1}} >> (WIDTH - SLICE_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_n;
    logic [2:0]         code_q, code_n;
    logic [WIDTH-1:0]   a_q, a_n;
    logic [WIDTH-1:0]   b_q, b_n;
    logic               carry_q, carry_n;
    logic [CNT_W-1:0]   idx_q, idx_n;
    logic [WIDTH-1:0]   result_n;
    logic               zero_n, illegal_n, in_ready_n, out_valid_n;

    // Operand mux: select slice idx of the latched operands.
    logic [31:0]        off;
    logic [SLICE_W-1:0] a_sl, b_sl, y_sl;
    logic               cout_sl, cmsb_sl;

    assign off  = 32'(idx_q) * SLICE_W;
    assign a_sl = SLICE_W'(a_q >> off);
    assign b_sl = SLICE_W'(b_q >> off);

    alu_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .code  (code_q),
        .cin   (carry_q),
        .y     (y_sl),
        .cout  (cout_sl),
        .c_msb (cmsb_sl)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            code_q    <= code_n;
            a_q       <= a_n;
            b_q       <= b_n;
            carry_q   <= carry_n;
            idx_q     <= idx_n;
            result    <= result_n;
            zero      <= zero_n;
            illegal   <= illegal_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        logic last;
        logic lt;
        state_n   = state_q;
        code_n    = code_q;
        a_n       = a_q;
        b_n       = b_q;
        carry_n   = carry_q;
        idx_n     = idx_q;
        result_n  = result;
        zero_n    = zero;
        illegal_n = illegal;
        last      = 1'b0;
        lt        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    code_n    = alu_ctrl_sig;
                    a_n       = src_a;
                    b_n       = src_b;
                    carry_n   = uses_sub(alu_ctrl_sig);
                    idx_n     = '0;
                    result_n  = '0;
                    zero_n    = 1'b0;
                    illegal_n = ~is_legal(alu_ctrl_sig);
                    state_n   = RUN;
                end
            end
            RUN: begin
`ifdef ALU_SERIAL_MULT_EN
                if (code_q == ALU_MULT) begin
                    // a shifts left, b shifts right: b_q[0] is multiplier bit idx
                    result_n = result + (b_q[0] ? a_q : '0);
                    a_n      = a_q << 1;
                    b_n      = b_q >> 1;
                    last     = (idx_q == CNT_W'(WIDTH - 1));
                end else
`endif
                begin
                    result_n = (result & ~(SMASK << off)) | (WIDTH'(y_sl) << off);
                    carry_n  = cout_sl;
                    last     = (idx_q == CNT_W'(NSLICE - 1));
                    if (last && code_q == ALU_SLT) begin
                        // signed less-than = sign of difference xor overflow
                        lt       = y_sl[SLICE_W-1] ^ (cmsb_sl ^ cout_sl);
                        result_n = WIDTH'(lt);
                    end
                end
                idx_n = idx_q + CNT_W'(1);
                if (last) begin
                    zero_n  = (result_n == '0);
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        in_ready_n  = (state_n == IDLE);
        out_valid_n = (state_n == DONE);
    end

endmodule
